// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the SIPO load controller: FSM encoding, byte geometry
// and the round-robin winner pick.
package sipo_ctrl_pkg;

  localparam int BYTE_BITS = 8;
  localparam int BIT_IDX_W = $clog2(BYTE_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // On contention the requester that did not own the previous frame wins.
  function automatic logic pick_winner(input logic v0, input logic v1, input logic last_grant);
    logic win;
    if (v0 && v1) begin
      win = ~last_grant;
    end else if (v1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Holds the captured byte and walks it out MSB first, one bit per advance.
module byte_serializer
  import sipo_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 load,
  input  logic [BYTE_BITS-1:0] data,
  input  logic                 advance,
  output logic                 s_in,
  output logic                 last_bit
);

  logic [BYTE_BITS-1:0] byte_r;
  logic [BIT_IDX_W-1:0] bit_cnt_r;

  // byte capture and bit counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_r    <= {BYTE_BITS{1'b0}};
      bit_cnt_r <= {BIT_IDX_W{1'b0}};
    end else if (clear) begin
      bit_cnt_r <= {BIT_IDX_W{1'b0}};
    end else if (load) begin
      byte_r    <= data;
      bit_cnt_r <= {BIT_IDX_W{1'b0}};
    end else if (advance) begin
      bit_cnt_r <= bit_cnt_r + BIT_IDX_W'(1);
    end
  end

  // serial bit and end-of-byte flag decoded from the counter
  always_comb begin
    s_in     = byte_r[BIT_IDX_W'(BYTE_BITS - 1) - bit_cnt_r];
    last_bit = (bit_cnt_r == BIT_IDX_W'(BYTE_BITS - 1));
  end

endmodule

// File: rtl/sipo_load_arbiter.sv
// Arbitrates two byte requesters and serialises a SIZE-bit frame into a
// downstream SIPO register; abort abandons the frame without publishing it.
module sipo_load_arbiter
  import sipo_ctrl_pkg::*;
#(
  parameter int SIZE = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [BYTE_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [BYTE_BITS-1:0] req1_data,
  output logic                 req1_ready,
  input  logic                 abort,
  output logic                 shift,
  output logic                 s_in,
  output logic                 busy,
  output logic                 grant,
  output logic                 frame_done,
  output logic                 key_valid
);

  localparam int NUM_BYTES = SIZE / BYTE_BITS;
  localparam int BCNT_W    = $clog2(NUM_BYTES);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NUM_BYTES - 1);

  state_e               state_r;
  state_e               state_s;
  logic                 grant_r;
  logic                 grant_s;
  logic [BCNT_W-1:0]    byte_cnt_r;
  logic                 key_valid_r;
  logic                 hs_s;
  logic                 leave_idle_s;
  logic                 shift_s;
  logic                 last_bit_s;
  logic                 more_bytes_s;
  logic [BYTE_BITS-1:0] sel_data_s;

  // handshake and data come only from the requester holding the grant
  always_comb begin
    sel_data_s = req0_data;
    hs_s       = 1'b0;
    if (grant_r) begin
      sel_data_s = req1_data;
      hs_s       = (state_r == LOAD) && req1_valid;
    end else begin
      sel_data_s = req0_data;
      hs_s       = (state_r == LOAD) && req0_valid;
    end
  end

  // shared decodes
  always_comb begin
    leave_idle_s = (state_r == IDLE) && (req0_valid || req1_valid);
    shift_s      = (state_r == SHIFT) && !abort;
    more_bytes_s = (byte_cnt_r < LAST_BYTE);
  end

  // next-state and arbitration
  always_comb begin
    state_s = state_r;
    grant_s = grant_r;
    case (state_r)
      IDLE: begin
        if (leave_idle_s) begin
          grant_s = pick_winner(req0_valid, req1_valid, grant_r);
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_s = IDLE;
        end else if (hs_s) begin
          state_s = SHIFT;
        end else begin
          state_s = LOAD;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_s = IDLE;
        end else if (last_bit_s) begin
          state_s = more_bytes_s ? LOAD : DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM, grant and byte counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      grant_r    <= 1'b1;
      byte_cnt_r <= {BCNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      grant_r <= grant_s;
      if (leave_idle_s) begin
        byte_cnt_r <= {BCNT_W{1'b0}};
      end else if (shift_s && last_bit_s && more_bytes_s) begin
        byte_cnt_r <= byte_cnt_r + BCNT_W'(1);
      end
    end
  end

  // key_valid starts set because the SIPO register resets to a valid default key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid_r <= 1'b1;
    end else if (leave_idle_s) begin
      key_valid_r <= 1'b0;
    end else if ((state_r == DONE) && !abort) begin
      key_valid_r <= 1'b1;
    end
  end

  byte_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .clear    (leave_idle_s),
    .load     (hs_s && !abort),
    .data     (sel_data_s),
    .advance  (shift_s),
    .s_in     (s_in),
    .last_bit (last_bit_s)
  );

  // outputs decoded from registered state; abort gates shift and frame_done at once
  always_comb begin
    shift      = shift_s;
    req0_ready = (state_r == LOAD) && !grant_r;
    req1_ready = (state_r == LOAD) && grant_r;
    busy       = (state_r != IDLE);
    grant      = grant_r;
    frame_done = (state_r == DONE) && !abort;
    key_valid  = key_valid_r;
  end

endmodule
